dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the pipeline MEM stage (CPU port) and a debug/DMA loader port (DBG port).
- Drives a variable-latency memory through a req/ack handshake and stalls the pipeline while a CPU access is outstanding.
- Counts stall cycles for the stall statistics the testbench prints.
- Sits between the EX_MEM pipeline register outputs and Data_Memory.

---
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: lets the pipeline MEM stage (CPU port) and a debug/DMA loader
// (DBG port) share one data-memory port. The memory has variable latency and
// uses a req/ack handshake. The pipeline is stalled while a CPU access is
// outstanding, and the number of stalled cycles is counted.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-low reset
//   cpu_req_i/we/addr/wdata           CPU access, held until the done cycle
//   cpu_rdata_o, stall_o              CPU read data (registered), stall request
//   dbg_valid_i/we/addr/wdata         debug access, held until dbg_ready_o
//   dbg_ready_o, dbg_rdata_o          one-cycle completion pulse, debug read data
//   mem_req_o/we/addr/wdata           memory request (level) and latched command
//   mem_rdata_i, mem_ack_i            memory read data and single-cycle ack
//   err_o                             sticky timeout flag
//   stall_cnt_o                       saturating count of stalled cycles
module dmem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              stall_o,
    input  logic              dbg_valid_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ready_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // The timeout counter only has to count 0 .. TIMEOUT-1.
    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StBusyCpu, StBusyDbg} state_e;

    state_e            state_q;
    logic              last_dbg_q;   // 1: DBG was granted last, so CPU wins a tie
    logic [TmoW-1:0]   tmo_q;
    logic              cpu_done_q;
    logic              dbg_ready_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic cpu_elig;
    logic dbg_elig;
    logic idle_free;
    logic grant_cpu;
    logic grant_dbg;
    logic tmo_hit;
    logic finish;

    always_comb begin
        cpu_elig  = cpu_req_i & ~cpu_done_q;
        dbg_elig  = dbg_valid_i & ~dbg_ready_q;
        // A done cycle never starts a new transaction, whichever port finished.
        idle_free = ~cpu_done_q & ~dbg_ready_q;
        grant_cpu = cpu_elig & (~dbg_elig | last_dbg_q);
        grant_dbg = dbg_elig & (~cpu_elig | ~last_dbg_q);
        tmo_hit   = (tmo_q == TmoW'(TIMEOUT - 1));
        finish    = mem_ack_i | tmo_hit;
    end

    // Gated by reset so every output reads 0 while the block is held in reset.
    assign stall_o = rst_i & cpu_req_i & ~cpu_done_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            last_dbg_q  <= 1'b1;
            tmo_q       <= '0;
            cpu_done_q  <= 1'b0;
            dbg_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            cpu_done_q  <= 1'b0;
            dbg_ready_q <= 1'b0;

            if (stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (idle_free && (grant_cpu || grant_dbg)) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= grant_cpu ? cpu_we_i    : dbg_we_i;
                        mem_addr_q  <= grant_cpu ? cpu_addr_i  : dbg_addr_i;
                        mem_wdata_q <= grant_cpu ? cpu_wdata_i : dbg_wdata_i;
                        last_dbg_q  <= grant_dbg;
                        tmo_q       <= '0;
                        state_q     <= grant_cpu ? StBusyCpu : StBusyDbg;
                    end
                end
                StBusyCpu, StBusyDbg: begin
                    if (finish) begin
                        mem_req_q <= 1'b0;
                        tmo_q     <= '0;
                        state_q   <= StIdle;
                        // An ack in the last allowed cycle still counts as an ack.
                        if (!mem_ack_i) begin
                            err_q <= 1'b1;
                        end
                        if (state_q == StBusyCpu) begin
                            cpu_done_q <= 1'b1;
                            if (!mem_ack_i) begin
                                cpu_rdata_q <= '0;
                            end else if (!mem_we_q) begin
                                cpu_rdata_q <= mem_rdata_i;
                            end
                        end else begin
                            dbg_ready_q <= 1'b1;
                            if (!mem_ack_i) begin
                                dbg_rdata_q <= '0;
                            end else if (!mem_we_q) begin
                                dbg_rdata_q <= mem_rdata_i;
                            end
                        end
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_ready_o = dbg_ready_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a table of single transactions plus hand-written
// sequences for timeout, asynchronous reset mid-access, round-robin arbitration
// and stall-counter saturation (second instance with a 3-bit counter).
module tb_dmem_arbiter;

    localparam logic [31:0] RrDbgAddr = 32'h0000_0200;
    localparam logic [31:0] RrCpuAddr = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (TIMEOUT = 4)
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        stall;
    logic        dbg_valid = 1'b0, dbg_we = 1'b0, dbg_ready;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0, dbg_rdata;
    logic        mem_req, mem_we, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] stall_cnt;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .stall_o(stall),
        .dbg_valid_i(dbg_valid), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_ready_o(dbg_ready), .dbg_rdata_o(dbg_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .err_o(err), .stall_cnt_o(stall_cnt)
    );

    // Saturation instance: CPU always requesting, memory never acks.
    logic        s_cpu_req = 1'b1;
    logic        s_zero1 = 1'b0;
    logic [31:0] s_zero32 = '0;
    logic [31:0] s_cpu_rdata, s_dbg_rdata, s_mem_addr, s_mem_wdata;
    logic        s_stall, s_dbg_ready, s_mem_req, s_mem_we, s_err;
    logic [2:0]  s_stall_cnt;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(3)) dut_sat (
        .clk_i(clk), .rst_i(rst_n),
        .cpu_req_i(s_cpu_req), .cpu_we_i(s_zero1), .cpu_addr_i(s_zero32),
        .cpu_wdata_i(s_zero32), .cpu_rdata_o(s_cpu_rdata), .stall_o(s_stall),
        .dbg_valid_i(s_zero1), .dbg_we_i(s_zero1), .dbg_addr_i(s_zero32),
        .dbg_wdata_i(s_zero32), .dbg_ready_o(s_dbg_ready), .dbg_rdata_o(s_dbg_rdata),
        .mem_req_o(s_mem_req), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr),
        .mem_wdata_o(s_mem_wdata), .mem_rdata_i(s_zero32), .mem_ack_i(s_zero1),
        .err_o(s_err), .stall_cnt_o(s_stall_cnt)
    );

    // Memory model: acks mem_lat cycles after mem_req rises; junk data otherwise.
    int          mem_lat = 0;
    logic [31:0] mem_data = '0;
    int          busy_cnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            if (busy_cnt == mem_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_data;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
            end
            busy_cnt++;
        end else begin
            busy_cnt = 0;
            mem_ack  = 1'b0;
        end
    end

    // Grant monitor: one entry per mem_req rising edge (1 = debug grant).
    logic req_prev = 1'b0;
    int   rises = 0;
    int   gn = 0;
    bit   gl [8];
    always @(negedge clk) begin
        if (mem_req && !req_prev) begin
            rises++;
            if (gn < 8) begin
                gl[gn] = (mem_addr == RrDbgAddr);
                gn++;
            end
        end
        req_prev = mem_req;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              output int cyc, output logic [31:0] rd, output logic l_we,
                              output logic [31:0] l_addr, output logic [31:0] l_wd);
        bit cap = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        #1;
        cyc = stall ? 1 : 0;
        l_we = 1'b0; l_addr = '0; l_wd = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_req && !cap) begin
                cap = 1; l_we = mem_we; l_addr = mem_addr; l_wd = mem_wdata;
            end
            if (!stall) break;
            cyc++;
        end
        rd = cpu_rdata;
        cpu_req = 1'b0;
    endtask

    task automatic dbg_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              output int cyc, output logic [31:0] rd, output logic l_we,
                              output logic [31:0] l_addr, output logic [31:0] l_wd);
        bit cap = 0;
        @(negedge clk);
        dbg_valid = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        cyc = 0;
        l_we = 1'b0; l_addr = '0; l_wd = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            if (mem_req && !cap) begin
                cap = 1; l_we = mem_we; l_addr = mem_addr; l_wd = mem_wdata;
            end
            if (dbg_ready) break;
        end
        rd = dbg_rdata;
        dbg_valid = 1'b0;
    endtask

    typedef struct {
        bit          dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] exp_rd;
        int          exp_cyc;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          cyc, cyc2, cyc3, cyc4;
        logic [31:0] rd, rd2, rd3, rd4, la, lw, la2, lw2;
        logic        lwe, lwe2;
        logic [31:0] cnt0;
        int          r0;

        tbl[0] = '{1'b0, 1'b0, 32'h0,  32'h0,    3, 32'h5,    32'h5,    5};
        tbl[1] = '{1'b1, 1'b1, 32'h8,  32'hDEAD, 1, 32'h1111, 32'h0,    3};
        tbl[2] = '{1'b1, 1'b0, 32'h10, 32'h0,    0, 32'h1234, 32'h1234, 2};
        tbl[3] = '{1'b0, 1'b1, 32'h20, 32'hCAFE, 2, 32'h2222, 32'h5,    4};
        tbl[4] = '{1'b0, 1'b0, 32'h24, 32'h0,    0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2};
        tbl[5] = '{1'b1, 1'b1, 32'h28, 32'hBEEF, 2, 32'h3333, 32'h1234, 4};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst mem_req", mem_req, 0);
        chk("rst stall", stall, 0);
        chk("rst dbg_ready", dbg_ready, 0);
        chk("rst cpu_rdata", cpu_rdata, 0);
        chk("rst dbg_rdata", dbg_rdata, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst err", err, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        chk("rst sat stall", s_stall, 0);
        rst_n = 1'b1;

        // Saturating counter climbs one per stalled cycle
        repeat (3) @(negedge clk);
        chk("sat climb", s_stall_cnt, 3);

        for (int i = 0; i < 6; i++) begin
            mem_lat = tbl[i].lat;
            mem_data = tbl[i].rdata;
            cnt0 = stall_cnt;
            r0 = rises;
            if (tbl[i].dbg) begin
                dbg_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, cyc, rd, lwe, la, lw);
            end else begin
                cpu_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, cyc, rd, lwe, la, lw);
            end
            chk($sformatf("vec%0d cycles", i), 64'(cyc), 64'(tbl[i].exp_cyc));
            chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d mem_we", i), lwe, tbl[i].we);
            chk($sformatf("vec%0d mem_addr", i), la, tbl[i].addr);
            if (tbl[i].we) chk($sformatf("vec%0d mem_wdata", i), lw, tbl[i].wdata);
            chk($sformatf("vec%0d req bursts", i), 64'(rises - r0), 1);
            chk($sformatf("vec%0d err", i), err, 0);
            chk($sformatf("vec%0d stall_cnt delta", i), stall_cnt - cnt0,
                tbl[i].dbg ? 32'd0 : 32'(tbl[i].exp_cyc));
            if (tbl[i].dbg) begin
                @(negedge clk);
                chk($sformatf("vec%0d ready pulse width", i), dbg_ready, 0);
            end
        end

        chk("sat hold 7", s_stall_cnt, 7);
        chk("sat err", s_err, 1);

        // Timeout: memory never acks, completes after 4 BUSY cycles
        mem_lat = 1000;
        cpu_access(1'b0, 32'h30, 32'h0, cyc, rd, lwe, la, lw);
        chk("tmo cycles", 64'(cyc), 5);
        chk("tmo rdata", rd, 0);
        chk("tmo err", err, 1);
        mem_lat = 0;
        mem_data = 32'h7;
        cpu_access(1'b0, 32'h34, 32'h0, cyc, rd, lwe, la, lw);
        chk("post-tmo cycles", 64'(cyc), 2);
        chk("post-tmo rdata", rd, 32'h7);
        chk("post-tmo err sticky", err, 1);
        chk("sat still 7", s_stall_cnt, 7);

        // Asynchronous reset in the middle of a CPU access
        mem_lat = 1000;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        repeat (2) @(negedge clk);
        chk("mid busy mem_req", mem_req, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst mem_req", mem_req, 0);
        chk("async rst stall", stall, 0);
        chk("async rst err", err, 0);
        chk("async rst stall_cnt", stall_cnt, 0);
        chk("async rst cpu_rdata", cpu_rdata, 0);
        chk("async rst mem_addr", mem_addr, 0);
        mem_lat = 1;
        mem_data = 32'h77;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("regrant mem_req", mem_req, 1);
        chk("regrant mem_addr", mem_addr, 32'h40);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stall) break;
            cyc++;
            @(negedge clk);
        end
        chk("regrant done", stall, 0);
        chk("regrant rdata", cpu_rdata, 32'h77);
        chk("regrant stall_cnt", stall_cnt, 3);
        cpu_req = 1'b0;

        // Round-robin from reset: CPU, DBG, CPU, DBG
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_lat = 1;
        mem_data = 32'h0;
        gn = 0;
        fork
            begin
                cpu_access(1'b0, RrCpuAddr, 32'h0, cyc, rd, lwe, la, lw);
                cpu_access(1'b0, RrCpuAddr, 32'h0, cyc2, rd2, lwe, la, lw);
            end
            begin
                dbg_access(1'b0, RrDbgAddr, 32'h0, cyc3, rd3, lwe2, la2, lw2);
                dbg_access(1'b0, RrDbgAddr, 32'h0, cyc4, rd4, lwe2, la2, lw2);
            end
        join
        chk("rr grants", 64'(gn), 4);
        chk("rr g0 cpu", gl[0], 0);
        chk("rr g1 dbg", gl[1], 1);
        chk("rr g2 cpu", gl[2], 0);
        chk("rr g3 dbg", gl[3], 1);
        chk("rr cpu1 wait", 64'(cyc), 3);
        chk("rr cpu2 wait", 64'(cyc2), 7);
        chk("rr dbg1 wait", 64'(cyc3), 7);
        chk("rr dbg2 wait", 64'(cyc4), 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
